run_sequencer: RTL and testbench
================================

// Module: run_sequencer
// PURPOSE
//  Parametrised multi-stage run timer for the washer controller; successor to the fixed
//  3-stage run controller. Latches per-stage durations and an enable mask, then counts each
//  enabled stage down in time units derived from clk. Supports pause/resume, abort and
//  zero-length/disabled stage skipping, and reports the stage index, remaining times and finish.
//  Sits between the top-level mode FSM (drives state) and the display/actuator logic.
// PARAMETERS
//  NUM_STAGES  3           number of run stages (1..8)
//  TIME_W      4           bits per stage duration, in time units
//  TICK_DIV    50000000    clk cycles per time unit (>=2)
//  Derived: SW=max(1,$clog2(NUM_STAGES)); TW=TIME_W+$clog2(NUM_STAGES+1)
// PORTS
//  clk          in   1               system clock, all state on rising edge
//  rst          in   1               asynchronous reset, active-high
//  state        in   3               mode command: 0 OFF, 1 SET, 3 RUN, 5 PAUSE, 6 ABORT, others HOLD
//  cfg_time     in   NUM_STAGES*TIME_W  stage i duration in bits [i*TIME_W +: TIME_W]
//  stage_en     in   NUM_STAGES      stage i runs only if stage_en[i]=1 and its time is nonzero
//  busy         out  1               1 while FSM is RUN or PAUSE
//  cur_stage    out  SW              index of the active stage (0 when not running)
//  remain       out  TIME_W          units left in the active stage
//  total_remain out  TW              remain + sum of the remaining enabled stages' times
//  stage_done   out  1               one-cycle pulse when a stage reaches 0
//  had_finish   out  1               level: all stages complete; held until OFF or SET
//  aborted      out  1               one-cycle pulse on ABORT from RUN/PAUSE
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs, latched config and tick counter = 0.
//  FSM states: IDLE, LOADED, RUN, PAUSE, DONE. The state input is sampled every clk edge.
//  - OFF (0) from any FSM state -> IDLE next cycle; config and all outputs cleared.
//  - SET (1) in IDLE/LOADED/DONE -> LOADED; cfg_time/stage_en latched every cycle while SET.
//    Clears had_finish. total_remain shows the sum of the latched enabled nonzero stages.
//    SET is ignored in RUN/PAUSE.
//  - RUN (3) from LOADED: the tick counter is cleared, cur_stage = lowest valid stage, and
//    remain = its time. If no stage is valid -> DONE (had_finish=1) next cycle, with no stage_done.
//  - RUN (3) from PAUSE: resume with the tick counter and remain unchanged.
//  - In RUN: the tick counter counts 0..TICK_DIV-1 and wraps. On wrap, remain and total_remain
//    each drop by 1. The first decrement occurs TICK_DIV cycles after RUN is entered.
//  - Decrement to remain=0: stage_done=1 for that cycle. The same edge loads the next higher
//    valid stage (cur_stage, remain). If none remains -> DONE: had_finish=1, busy=0,
//    cur_stage=0, remain=0.
//  - PAUSE (5) in RUN -> PAUSE: all counters frozen, busy stays 1. PAUSE in other FSM states = HOLD.
//  - ABORT (6) in RUN/PAUSE -> LOADED: aborted pulses 1 cycle; config is retained.
//    remain/cur_stage = 0; total_remain is recomputed from the config. had_finish stays 0.
//  - HOLD codes (2, 4, 7) and commands invalid for the current FSM state leave the state unchanged.
//  - cfg_time/stage_en changes while RUN/PAUSE have no effect; only latched copies are used.
//  - Stages with time 0 or en=0 are skipped with zero cycles spent.
//  - Widths: total_remain never overflows TW; remain never underflows, because a stage at 0
//    is never decremented.
//  - Async rst mid-run: immediate return to reset values, with no stage_done or aborted pulse.
// TESTING  (NUM_STAGES=3, TIME_W=4, TICK_DIV=4)
//  1 cfg={3,0,2} en=111, SET then RUN -> stage0 runs 8 cycles; stage_done pulses at cycles 8
//    and 20 after RUN; stage1 skipped; had_finish=1 at 20 cycles; total_remain 5->0.
//  2 Same config, PAUSE 5 cycles after RUN, hold 10 cycles, then RUN -> the first decrement
//    lands 3 cycles after resume; finish at 30 cycles after the first RUN.
//  3 en=000 (or all times 0), RUN -> had_finish=1 next cycle; no stage_done; busy never 1.
//  4 ABORT mid stage2 -> aborted 1-cycle pulse, FSM LOADED, remain=0, total_remain=5;
//    RUN again restarts from stage0 with remain=3.
//  5 rst asserted mid-RUN -> all outputs 0 asynchronously; after release, RUN without SET
//    gives immediate DONE (config cleared).
//  6 cfg={15,15,15} -> total_remain=45 (fits TW=6); OFF in DONE clears had_finish next cycle.

Source files
------------

// File: rtl/run_sequencer.sv
// Multi-stage run timer: latches per-stage durations and an enable mask, then counts
// each valid stage down in units of TICK_DIV clocks with pause, resume and abort.
module run_sequencer #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned TIME_W     = 4,
  parameter int unsigned TICK_DIV   = 50000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2:0]                     state,
  input  logic [NUM_STAGES*TIME_W-1:0]   cfg_time,
  input  logic [NUM_STAGES-1:0]          stage_en,
  output logic                           busy,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] cur_stage,
  output logic [TIME_W-1:0]              remain,
  output logic [TIME_W+$clog2(NUM_STAGES+1)-1:0] total_remain,
  output logic                           stage_done,
  output logic                           had_finish,
  output logic                           aborted
);

  localparam int unsigned SW    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned TW    = TIME_W + $clog2(NUM_STAGES + 1);
  localparam int unsigned CFG_W = NUM_STAGES * TIME_W;
  localparam int unsigned CW    = $clog2(TICK_DIV);

  localparam logic [2:0] CMD_OFF   = 3'd0;
  localparam logic [2:0] CMD_SET   = 3'd1;
  localparam logic [2:0] CMD_RUN   = 3'd3;
  localparam logic [2:0] CMD_PAUSE = 3'd5;
  localparam logic [2:0] CMD_ABORT = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUN,
    S_PAUSE,
    S_DONE
  } fsm_t;

  fsm_t              fsm;
  logic [CFG_W-1:0]  cfg_lat;
  logic [NUM_STAGES-1:0] en_lat;
  logic [CW-1:0]     tick;

  logic [TW-1:0]     sum_lat;
  logic [TW-1:0]     sum_in;
  logic              first_found;
  logic [SW-1:0]     first_idx;
  logic [TIME_W-1:0] first_time;
  logic              next_found;
  logic [SW-1:0]     next_idx;
  logic [TIME_W-1:0] next_time;
  logic              tick_wrap;
  logic              run_step;
  logic              cfg_idle_ok;

  // Stage sums and the first / next-higher valid stage of the latched configuration.
  always_comb begin
    sum_lat     = '0;
    sum_in      = '0;
    first_found = 1'b0;
    first_idx   = '0;
    first_time  = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    next_time   = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (en_lat[i] && (cfg_lat[i*TIME_W +: TIME_W] != '0)) begin
        sum_lat = sum_lat + TW'(cfg_lat[i*TIME_W +: TIME_W]);
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = SW'(i);
          first_time  = cfg_lat[i*TIME_W +: TIME_W];
        end
        if (!next_found && (i > int'(cur_stage))) begin
          next_found = 1'b1;
          next_idx   = SW'(i);
          next_time  = cfg_lat[i*TIME_W +: TIME_W];
        end
      end
      if (stage_en[i] && (cfg_time[i*TIME_W +: TIME_W] != '0)) begin
        sum_in = sum_in + TW'(cfg_time[i*TIME_W +: TIME_W]);
      end
    end
  end

  assign tick_wrap   = (tick == CW'(TICK_DIV - 1));
  assign cfg_idle_ok = (fsm == S_IDLE) || (fsm == S_LOADED) || (fsm == S_DONE);

  // Time advances on every edge that leaves the FSM in RUN from RUN or PAUSE.
  always_comb begin
    run_step = 1'b0;
    if (fsm == S_RUN) begin
      run_step = (state != CMD_OFF) && (state != CMD_PAUSE) && (state != CMD_ABORT);
    end else if (fsm == S_PAUSE) begin
      run_step = (state == CMD_RUN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm          <= S_IDLE;
      cfg_lat      <= '0;
      en_lat       <= '0;
      tick         <= '0;
      busy         <= 1'b0;
      cur_stage    <= '0;
      remain       <= '0;
      total_remain <= '0;
      stage_done   <= 1'b0;
      had_finish   <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      stage_done <= 1'b0;
      aborted    <= 1'b0;

      case (state)
        CMD_OFF: begin
          fsm          <= S_IDLE;
          cfg_lat      <= '0;
          en_lat       <= '0;
          tick         <= '0;
          busy         <= 1'b0;
          cur_stage    <= '0;
          remain       <= '0;
          total_remain <= '0;
          had_finish   <= 1'b0;
        end
        CMD_SET: begin
          if (cfg_idle_ok) begin
            fsm          <= S_LOADED;
            cfg_lat      <= cfg_time;
            en_lat       <= stage_en;
            busy         <= 1'b0;
            cur_stage    <= '0;
            remain       <= '0;
            total_remain <= sum_in;
            had_finish   <= 1'b0;
          end
        end
        CMD_RUN: begin
          if ((fsm == S_IDLE) || (fsm == S_LOADED)) begin
            tick <= '0;
            if (first_found) begin
              fsm          <= S_RUN;
              busy         <= 1'b1;
              cur_stage    <= first_idx;
              remain       <= first_time;
              total_remain <= sum_lat;
            end else begin
              fsm          <= S_DONE;
              busy         <= 1'b0;
              cur_stage    <= '0;
              remain       <= '0;
              total_remain <= '0;
              had_finish   <= 1'b1;
            end
          end else if (fsm == S_PAUSE) begin
            fsm <= S_RUN;
          end
        end
        CMD_PAUSE: begin
          if (fsm == S_RUN) begin
            fsm <= S_PAUSE;
          end
        end
        CMD_ABORT: begin
          if ((fsm == S_RUN) || (fsm == S_PAUSE)) begin
            fsm          <= S_LOADED;
            tick         <= '0;
            busy         <= 1'b0;
            cur_stage    <= '0;
            remain       <= '0;
            total_remain <= sum_lat;
            aborted      <= 1'b1;
          end
        end
        default: ;
      endcase

      // Unit countdown; a finished stage hands over to the next valid one on the same edge.
      if (run_step) begin
        if (tick_wrap) begin
          tick <= '0;
          if (remain != '0) begin
            total_remain <= total_remain - TW'(1);
            if (remain == TIME_W'(1)) begin
              stage_done <= 1'b1;
              if (next_found) begin
                cur_stage <= next_idx;
                remain    <= next_time;
              end else begin
                fsm          <= S_DONE;
                busy         <= 1'b0;
                cur_stage    <= '0;
                remain       <= '0;
                total_remain <= '0;
                had_finish   <= 1'b1;
              end
            end else begin
              remain <= remain - TIME_W'(1);
            end
          end
        end else begin
          tick <= tick + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: vector table, hand-written corner sequences and
// randomized commands compared against an elapsed-time reference model.
module tb_run_sequencer;

  localparam int NS = 3;
  localparam int TD = 4;

  localparam int M_IDLE = 0, M_LOADED = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  state = 3'd0;
  logic [11:0] cfg_time = '0;
  logic [2:0]  stage_en = '0;
  logic        busy;
  logic [1:0]  cur_stage;
  logic [3:0]  remain;
  logic [5:0]  total_remain;
  logic        stage_done;
  logic        had_finish;
  logic        aborted;

  run_sequencer #(.NUM_STAGES(NS), .TIME_W(4), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .state(state), .cfg_time(cfg_time), .stage_en(stage_en),
    .busy(busy), .cur_stage(cur_stage), .remain(remain), .total_remain(total_remain),
    .stage_done(stage_done), .had_finish(had_finish), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode, latched config and number of elapsed run cycles.
  int          m_mode = M_IDLE;
  logic [11:0] m_cfg  = '0;
  logic [2:0]  m_en   = '0;
  int          m_el   = 0;
  bit          m_fin  = 0, m_sd = 0, m_ab = 0;

  typedef struct {
    logic [2:0] cmd; logic [11:0] cfg; logic [2:0] en;
    int busy; int cur; int rem; int tot; int sd; int fin; int ab;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int stime(input int i);
    return (m_en[i] && m_cfg[i*4 +: 4] != 4'd0) ? int'(m_cfg[i*4 +: 4]) : 0;
  endfunction

  function automatic int total();
    int s = 0;
    for (int i = 0; i < NS; i++) s += stime(i);
    return s;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_cfg = '0; m_en = '0; m_el = 0; m_fin = 0; m_sd = 0; m_ab = 0;
  endtask

  task automatic advance();
    int u, cum;
    m_el++;
    if (m_el % TD == 0) begin
      u = m_el / TD;
      cum = 0;
      for (int i = 0; i < NS; i++) begin
        if (stime(i) > 0) begin
          cum += stime(i);
          if (cum == u) m_sd = 1;
        end
      end
      if (u == total()) begin m_mode = M_DONE; m_fin = 1; end
    end
  endtask

  task automatic model_step(input logic [2:0] c, input logic [11:0] cf, input logic [2:0] en);
    bool_idle_ok: begin end
    m_sd = 0; m_ab = 0;
    case (c)
      3'd0: begin m_mode = M_IDLE; m_cfg = '0; m_en = '0; m_el = 0; m_fin = 0; end
      3'd1: begin
        if (m_mode == M_IDLE || m_mode == M_LOADED || m_mode == M_DONE) begin
          m_mode = M_LOADED; m_cfg = cf; m_en = en; m_fin = 0;
        end else if (m_mode == M_RUN) advance();
      end
      3'd3: begin
        if (m_mode == M_IDLE || m_mode == M_LOADED) begin
          m_el = 0;
          if (total() == 0) begin m_mode = M_DONE; m_fin = 1; end
          else m_mode = M_RUN;
        end else if (m_mode == M_RUN || m_mode == M_PAUSE) begin
          m_mode = M_RUN;
          advance();
        end
      end
      3'd5: if (m_mode == M_RUN) m_mode = M_PAUSE;
      3'd6: if (m_mode == M_RUN || m_mode == M_PAUSE) begin m_mode = M_LOADED; m_ab = 1; end
      default: if (m_mode == M_RUN) advance();
    endcase
  endtask

  task automatic check_all();
    int e_busy = 0, e_cur = 0, e_rem = 0, e_tot = 0, u, cum;
    bit found = 0;
    if (m_mode == M_RUN || m_mode == M_PAUSE) begin
      e_busy = 1;
      u = m_el / TD;
      cum = 0;
      for (int i = 0; i < NS; i++) begin
        if (!found && stime(i) > 0) begin
          cum += stime(i);
          if (u < cum) begin found = 1; e_cur = i; e_rem = cum - u; end
        end
      end
      e_tot = total() - u;
    end else if (m_mode == M_LOADED) begin
      e_tot = total();
    end
    chk("busy", int'(busy), e_busy);
    chk("cur_stage", int'(cur_stage), e_cur);
    chk("remain", int'(remain), e_rem);
    chk("total_remain", int'(total_remain), e_tot);
    chk("stage_done", int'(stage_done), int'(m_sd));
    chk("had_finish", int'(had_finish), int'(m_fin));
    chk("aborted", int'(aborted), int'(m_ab));
  endtask

  task automatic step(input logic [2:0] c, input logic [11:0] cf, input logic [2:0] en);
    state = c; cfg_time = cf; stage_en = en;
    @(posedge clk);
    model_step(c, cf, en);
    @(negedge clk);
  endtask

  task automatic cycle(input logic [2:0] c, input logic [11:0] cf, input logic [2:0] en);
    step(c, cf, en);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input logic [2:0] c, input logic [11:0] cf, input logic [2:0] en,
                     input int b, input int cs, input int r, input int t,
                     input int sd, input int f, input int ab);
    vec_t v;
    v.cmd = c; v.cfg = cf; v.en = en; v.busy = b; v.cur = cs; v.rem = r; v.tot = t;
    v.sd = sd; v.fin = f; v.ab = ab;
    vecs.push_back(v);
  endtask

  initial begin
    int sd_edge, fin_edge, r;
    logic [2:0] cmd;

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_total", int'(total_remain), 0);
    chk("rst_finish", int'(had_finish), 0);
    chk("rst_remain", int'(remain), 0);
    rst = 1'b0;
    model_reset();

    // Vector table: cfg {3,0,2}, expected outputs after each edge.
    add(3'd0, 12'h302, 3'b111, 0, 0, 0, 0, 0, 0, 0);
    add(3'd1, 12'h302, 3'b111, 0, 0, 0, 5, 0, 0, 0);
    add(3'd3, 12'h000, 3'b000, 1, 0, 2, 5, 0, 0, 0);
    add(3'd2, 12'h000, 3'b000, 1, 0, 2, 5, 0, 0, 0);
    add(3'd3, 12'h000, 3'b000, 1, 0, 2, 5, 0, 0, 0);
    add(3'd3, 12'h000, 3'b000, 1, 0, 2, 5, 0, 0, 0);
    add(3'd3, 12'h000, 3'b000, 1, 0, 1, 4, 0, 0, 0);
    add(3'd5, 12'h000, 3'b000, 1, 0, 1, 4, 0, 0, 0);
    add(3'd1, 12'hFFF, 3'b111, 1, 0, 1, 4, 0, 0, 0);
    add(3'd6, 12'h000, 3'b000, 0, 0, 0, 5, 0, 0, 1);
    for (int k = 0; k < 4; k++) add(3'd3, 12'h000, 3'b000, 1, 0, 2, 5, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(3'd3, 12'h000, 3'b000, 1, 0, 1, 4, 0, 0, 0);
    add(3'd3, 12'h000, 3'b000, 1, 2, 3, 3, 1, 0, 0);
    add(3'd3, 12'h000, 3'b000, 1, 2, 3, 3, 0, 0, 0);
    add(3'd0, 12'h000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add(3'd1, 12'h302, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    add(3'd3, 12'h302, 3'b111, 0, 0, 0, 0, 0, 1, 0);
    add(3'd3, 12'h302, 3'b111, 0, 0, 0, 0, 0, 1, 0);
    add(3'd1, 12'h302, 3'b101, 0, 0, 0, 5, 0, 0, 0);
    add(3'd0, 12'h000, 3'b000, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      step(vecs[k].cmd, vecs[k].cfg, vecs[k].en);
      chk($sformatf("vec%0d_busy", k), int'(busy), vecs[k].busy);
      chk($sformatf("vec%0d_cur", k), int'(cur_stage), vecs[k].cur);
      chk($sformatf("vec%0d_remain", k), int'(remain), vecs[k].rem);
      chk($sformatf("vec%0d_total", k), int'(total_remain), vecs[k].tot);
      chk($sformatf("vec%0d_done", k), int'(stage_done), vecs[k].sd);
      chk($sformatf("vec%0d_finish", k), int'(had_finish), vecs[k].fin);
      chk($sformatf("vec%0d_aborted", k), int'(aborted), vecs[k].ab);
    end

    // Pause 5 cycles after RUN for 10 cycles: handover at edge 18, finish at edge 30.
    cycle(3'd1, 12'h302, 3'b111);
    cycle(3'd3, 12'h000, 3'b000);
    sd_edge = -1; fin_edge = -1;
    for (int n = 1; n <= 60 && fin_edge < 0; n++) begin
      cycle((n >= 5 && n <= 14) ? 3'd5 : 3'd3, 12'h000, 3'b000);
      if (stage_done && sd_edge < 0) sd_edge = n;
      if (had_finish) fin_edge = n;
    end
    chk("pause_first_done_edge", sd_edge, 18);
    chk("pause_finish_edge", fin_edge, 30);

    // All stage times zero with every stage enabled: immediate finish.
    cycle(3'd1, 12'h000, 3'b111);
    cycle(3'd3, 12'h000, 3'b111);
    chk("zero_finish", int'(had_finish), 1);
    chk("zero_busy", int'(busy), 0);
    chk("zero_done", int'(stage_done), 0);

    // Abort inside stage2 of {2,0,3}, then restart from stage0.
    cycle(3'd1, 12'h203, 3'b111);
    cycle(3'd3, 12'h000, 3'b000);
    for (int n = 0; n < 14; n++) cycle(3'd3, 12'h000, 3'b000);
    chk("pre_abort_stage", int'(cur_stage), 2);
    cycle(3'd6, 12'h000, 3'b000);
    chk("abort_pulse", int'(aborted), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_remain", int'(remain), 0);
    chk("abort_total", int'(total_remain), 5);
    chk("abort_finish", int'(had_finish), 0);
    cycle(3'd3, 12'h000, 3'b000);
    chk("restart_pulse_gone", int'(aborted), 0);
    chk("restart_stage", int'(cur_stage), 0);
    chk("restart_remain", int'(remain), 3);

    // Asynchronous reset mid-run, then RUN without SET finishes at once.
    cycle(3'd3, 12'h000, 3'b000);
    do_reset();
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_total", int'(total_remain), 0);
    cycle(3'd3, 12'h302, 3'b111);
    chk("post_rst_finish", int'(had_finish), 1);
    chk("post_rst_busy", int'(busy), 0);

    // Maximum durations: total 45, finish after 180 cycles, OFF clears finish.
    cycle(3'd1, 12'hFFF, 3'b111);
    chk("max_total", int'(total_remain), 45);
    cycle(3'd3, 12'h000, 3'b000);
    fin_edge = -1;
    for (int n = 1; n <= 200 && fin_edge < 0; n++) begin
      cycle(3'd3, 12'h000, 3'b000);
      if (had_finish) fin_edge = n;
    end
    chk("max_finish_edge", fin_edge, 180);
    cycle(3'd0, 12'h000, 3'b000);
    chk("off_clears_finish", int'(had_finish), 0);

    // Randomized command stream against the model.
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) cmd = 3'd0;
      else if (r < 10) cmd = 3'd1;
      else if (r < 75) cmd = 3'd3;
      else if (r < 82) cmd = 3'd5;
      else if (r < 85) cmd = 3'd6;
      else begin
        case ($urandom_range(0, 2))
          0: cmd = 3'd2;
          1: cmd = 3'd4;
          default: cmd = 3'd7;
        endcase
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else cycle(cmd, {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
                 3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
